// File: rtl/instruction_issuer.sv
// Queues ADDU/SUBU requests and issues them one at a time to the execution unit; the response appears EXEC_LAT+1 edges after the request handshake.
// req_ready drops while the FIFO is full; resp_* stay stable until resp_ready. Build option ISSUER_ILLEGAL_CHECK_EN traps 2'b1x opcodes.
module instruction_issuer #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 4,
    parameter int EXEC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carryout,
    output logic             resp_error,
    output logic             eu_reset,
    output logic             eu_enable,
    output logic [1:0]       eu_instruction,
    output logic [WIDTH-1:0] eu_op1,
    output logic [WIDTH-1:0] eu_op2,
    input  logic [WIDTH-1:0] eu_result,
    input  logic             eu_carryout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
    } req_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] lat_cnt;
    logic          issue;
    logic          capture;
    logic          fault;
    logic          resp_clr;
    logic          illegal_head;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !reset && !full;
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr];
    assign eu_enable = (state == EXEC);

`ifdef ISSUER_ILLEGAL_CHECK_EN
    assign illegal_head = head.op[1];
`else
    assign illegal_head = 1'b0;
`endif

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: req_op, op1: req_op1, op2: req_op2};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        fault     = 1'b0;
        resp_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (illegal_head) begin
                        fault     = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_valid && resp_ready) begin
                    resp_clr = 1'b1;
                    // Back-to-back: the next queued request skips IDLE.
                    if (!empty) begin
                        pop = 1'b1;
                        if (illegal_head) begin
                            fault     = 1'b1;
                            state_nxt = RESP;
                        end else begin
                            issue     = 1'b1;
                            state_nxt = EXEC;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            eu_reset       <= 1'b1;
            eu_instruction <= 2'b00;
            eu_op1         <= '0;
            eu_op2         <= '0;
            resp_valid     <= 1'b0;
            resp_result    <= '0;
            resp_carryout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            eu_reset <= 1'b0;
            if (issue) begin
                eu_instruction <= head.op;
                eu_op1         <= head.op1;
                eu_op2         <= head.op2;
                lat_cnt        <= CW'(EXEC_LAT - 1);
            end else if (state == EXEC && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - CW'(1);
            end
            if (capture) begin
                resp_valid    <= 1'b1;
                resp_result   <= eu_result;
                resp_carryout <= eu_carryout;
            end else if (fault) begin
                resp_valid    <= 1'b1;
                resp_result   <= '0;
                resp_carryout <= 1'b0;
            end else if (resp_clr) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUER_ILLEGAL_CHECK_EN
    logic error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (capture) begin
            error_q <= 1'b0;
        end else if (fault) begin
            error_q <= 1'b1;
        end
    end

    assign resp_error = error_q;
`else
    assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_issuer.sv
// Bench for instruction_issuer: default instance plus an EXEC_LAT=3 instance, each driving a behavioural ADDU/SUBU stand-in.
module tb_instruction_issuer;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         req_valid, req_ready, resp_valid, resp_ready, resp_carryout, resp_error;
    logic         eu_reset, eu_enable, eu_carryout;
    logic [1:0]   req_op, eu_instruction;
    logic [W-1:0] req_op1, req_op2, resp_result, eu_op1, eu_op2, eu_result;

    logic         b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_carryout, b_resp_error;
    logic         b_eu_reset, b_eu_enable, b_eu_carryout;
    logic [1:0]   b_req_op, b_eu_instruction;
    logic [W-1:0] b_req_op1, b_req_op2, b_resp_result, b_eu_op1, b_eu_op2, b_eu_result;

    // Stand-in unit: ADDU reports carry-out active-low, SUBU reports borrow, 2'b1x returns op1^op2.
    function automatic logic [W:0] eu_model(input logic en, input logic [1:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        if (!en) return '0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                return {~s[W], s[W-1:0]};
            end
            2'b01:   return {(a < b), a - b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {eu_carryout, eu_result}     = eu_model(eu_enable, eu_instruction, eu_op1, eu_op2);
    assign {b_eu_carryout, b_eu_result} = eu_model(b_eu_enable, b_eu_instruction, b_eu_op1, b_eu_op2);

    instruction_issuer u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_carryout(resp_carryout), .resp_error(resp_error),
        .eu_reset(eu_reset), .eu_enable(eu_enable), .eu_instruction(eu_instruction),
        .eu_op1(eu_op1), .eu_op2(eu_op2), .eu_result(eu_result), .eu_carryout(eu_carryout)
    );

    instruction_issuer #(.EXEC_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_op1(b_req_op1), .req_op2(b_req_op2),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_result(b_resp_result),
        .resp_carryout(b_resp_carryout), .resp_error(b_resp_error),
        .eu_reset(b_eu_reset), .eu_enable(b_eu_enable), .eu_instruction(b_eu_instruction),
        .eu_op1(b_eu_op1), .eu_op2(b_eu_op2), .eu_result(b_eu_result), .eu_carryout(b_eu_carryout)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         co;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         err;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   en_cnt = 0;
    int   b_n = 0;
    int   b_t [8];
    logic [W-1:0] b_res [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        exp_t e;
        if (eu_enable) en_cnt++;
        if (!reset && resp_valid && resp_ready) begin
            resp_cnt++;
            check("resp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_result", resp_result, e.res);
                check("resp_carryout", 64'(resp_carryout), 64'(e.co));
                check("resp_error", 64'(resp_error), 64'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_resp_valid && b_resp_ready && b_n < 8) begin
            b_t[b_n]   = cyc;
            b_res[b_n] = b_resp_result;
            b_n++;
        end
    end

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] xr, input logic xc, input logic xe);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        if (req_ready) sb.push_back('{res: xr, co: xc, err: xe});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic b_send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        b_req_valid = 1'b1;
        b_req_op    = op;
        b_req_op1   = a;
        b_req_op2   = b;
        @(negedge clk);
        while (!b_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(sb.size() == 0 && !resp_valid && !eu_enable) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_resp_carryout", 64'(resp_carryout), 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_eu_enable", 64'(eu_enable), 64'd0);
        check("rst_eu_instruction", 64'(eu_instruction), 64'd0);
        check("rst_eu_op1", eu_op1, 64'd0);
        check("rst_eu_op2", eu_op2, 64'd0);
        check("rst_eu_reset", 64'(eu_reset), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int base;
        int en_base;

        reset = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_op1 = '0; req_op2 = '0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_op = 2'b00; b_req_op1 = '0; b_req_op2 = '0; b_resp_ready = 1'b1;

        vecs[0] = '{op: 2'b00, a: 64'd5, b: 64'd3, res: 64'd8, co: 1'b1, err: 1'b0};
        vecs[1] = '{op: 2'b01, a: 64'd0, b: 64'd1, res: 64'hFFFF_FFFF_FFFF_FFFF, co: 1'b1, err: 1'b0};
        vecs[2] = '{op: 2'b00, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, res: 64'd0, co: 1'b0, err: 1'b0};
        vecs[3] = '{op: 2'b01, a: 64'd10, b: 64'd3, res: 64'd7, co: 1'b0, err: 1'b0};
        vecs[4] = '{op: 2'b00, a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000,
                    res: 64'd0, co: 1'b0, err: 1'b0};
        vecs[5] = '{op: 2'b01, a: 64'd3, b: 64'd3, res: 64'd0, co: 1'b0, err: 1'b0};
`ifdef ISSUER_ILLEGAL_CHECK_EN
        vecs[6] = '{op: 2'b10, a: 64'h1234, b: 64'h0F0F, res: 64'd0, co: 1'b0, err: 1'b1};
`else
        vecs[6] = '{op: 2'b10, a: 64'h1234, b: 64'h0F0F, res: 64'h1D3B, co: 1'b0, err: 1'b0};
`endif

        // Reset values, then eu_reset lingers until the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        check("eu_reset_first_edge", 64'(eu_reset), 64'd1);
        check("req_ready_after_rst", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("eu_reset_released", 64'(eu_reset), 64'd0);

        // Single ADDU: latency and enable width.
        en_base = en_cnt;
        send(2'b00, 64'd5, 64'd3, 64'd8, 1'b1, 1'b0);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            #1;
            if (resp_valid) break;
        end
        check("resp_latency", 64'(k), 64'd2);
        wait_idle();
        check("eu_enable_cycles", 64'(en_cnt - en_base), 64'd1);
        check("eu_op1_hold", eu_op1, 64'd5);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].err);
        end
        wait_idle();

        // Lone illegal opcode: the unit must not be enabled when trapping.
        en_base = en_cnt;
`ifdef ISSUER_ILLEGAL_CHECK_EN
        send(2'b11, 64'hFF00, 64'h0FF0, 64'd0, 1'b0, 1'b1);
        wait_idle();
        check("illegal_enable_cycles", 64'(en_cnt - en_base), 64'd0);
`else
        send(2'b11, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0, 1'b0);
        wait_idle();
        check("illegal_enable_cycles", 64'(en_cnt - en_base), 64'd1);
`endif

        // Stalled consumer: four queued plus one in flight, then a sixth waits.
        resp_ready = 1'b0;
        base = resp_cnt;
        for (int i = 1; i <= 5; i++) begin
            send(2'b00, 64'(i * 100), 64'(i), 64'(i * 101), 1'b1, 1'b0);
        end
        check("full_backpressure", 64'(req_ready), 64'd0);
        fork
            send(2'b01, 64'd50, 64'd7, 64'd43, 1'b0, 1'b0);
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("still_full", 64'(req_ready), 64'd0);
        check("no_resp_while_stalled", 64'(resp_cnt - base), 64'd0);
        resp_ready = 1'b1;
        wait_idle();
        check("drain_count", 64'(resp_cnt - base), 64'd6);
        check("held_req_taken", 64'(req_valid), 64'd0);

        // EXEC_LAT=3 instance: back-to-back spacing.
        b_send(2'b00, 64'd1, 64'd2);
        b_send(2'b01, 64'd9, 64'd4);
        b_send(2'b00, 64'd7, 64'd7);
        k = 0;
        while (b_n < 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("b2b_count", 64'(b_n), 64'd3);
        check("b2b_gap1", 64'(b_t[1] - b_t[0]), 64'd4);
        check("b2b_gap2", 64'(b_t[2] - b_t[1]), 64'd4);
        check("b2b_res0", b_res[0], 64'd3);
        check("b2b_res1", b_res[1], 64'd5);
        check("b2b_res2", b_res[2], 64'd14);

        // Reset while executing with two requests still queued.
        send(2'b00, 64'd1, 64'd1, 64'd2, 1'b1, 1'b0);
        send(2'b00, 64'd2, 64'd2, 64'd4, 1'b1, 1'b0);
        send(2'b00, 64'd3, 64'd3, 64'd6, 1'b1, 1'b0);
        send(2'b00, 64'd4, 64'd4, 64'd8, 1'b1, 1'b0);
        k = 0;
        while (!(eu_enable && eu_op1 == 64'd2) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("exec_reached", 64'(eu_enable && eu_op1 == 64'd2), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        base = resp_cnt;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("eu_reset_post_midop", 64'(eu_reset), 64'd1);
        @(posedge clk);
        #1;
        check("eu_reset_clear_midop", 64'(eu_reset), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("no_resp_after_reset", 64'(resp_cnt - base), 64'd0);
        check("idle_after_reset", 64'(resp_valid || eu_enable), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
